// File: rtl/y_tile_word_packer_pkg.sv
// Shared types and derived sizes for the y-axis tile-to-word packer.
// Default geometry: 4x16-bit tiles packed into 256-bit words, 256-element vectors.
package ypack_pkg;
  localparam int YP_TILE_SIZE  = 4;
  localparam int YP_DATA_WIDTH = 16;
  localparam int YP_DATA_W     = 256;
  localparam int YP_D          = 256;
  localparam int TPW = YP_DATA_W / (YP_TILE_SIZE * YP_DATA_WIDTH);
  localparam int WPV = YP_D * YP_DATA_WIDTH / YP_DATA_W;
  localparam int TCW = (TPW > 1) ? $clog2(TPW) : 1;
  localparam int WCW = (WPV > 1) ? $clog2(WPV) : 1;

  typedef logic signed [YP_DATA_WIDTH-1:0] tile_t [YP_TILE_SIZE-1:0];
  typedef logic [YP_DATA_W-1:0] word_t;
endpackage

// File: rtl/y_tile_word_packer_if.sv
// Tile input stream and packed word output stream of the packer.
// master = packer side, slave = producer/consumer side.
interface y_tile_word_packer_if;
  import ypack_pkg::*;
  logic  y_axis_TVALID;
  logic  y_axis_TREADY;
  tile_t y_axis_TDATA;
  logic  m_axis_TVALID;
  logic  m_axis_TREADY;
  word_t m_axis_TDATA;
  logic  m_axis_TLAST;
  logic [WCW-1:0] word_idx;

  modport master (
    input  y_axis_TVALID, y_axis_TDATA, m_axis_TREADY,
    output y_axis_TREADY, m_axis_TVALID, m_axis_TDATA,
    output m_axis_TLAST, word_idx
  );
  modport slave (
    output y_axis_TVALID, y_axis_TDATA, m_axis_TREADY,
    input  y_axis_TREADY, m_axis_TVALID, m_axis_TDATA,
    input  m_axis_TLAST, word_idx
  );
endinterface

// File: rtl/y_tile_word_packer_out_reg.sv
// Single-entry output word register (y_word_out_reg) with valid/ready.
// Loads only when empty or draining; raises vec_done after a TLAST handshake.
module y_word_out_reg
  import ypack_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  word_t          load_data,
  input  logic           load_last,
  input  logic [WCW-1:0] load_idx,
  input  logic           ready,
  output logic           valid,
  output word_t          data,
  output logic           last,
  output logic [WCW-1:0] idx,
  output logic           vec_done
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      data     <= '0;
      last     <= 1'b0;
      idx      <= '0;
      vec_done <= 1'b0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
        last  <= load_last;
        idx   <= load_idx;
      end else if (ready) begin
        valid <= 1'b0;
      end
      vec_done <= valid && ready && last;
    end
  end
endmodule

// File: rtl/y_tile_word_packer.sv
// Packs y-axis tiles into output words, marks vector ends, supports flush.
// Optional YPACK_PERF_CNT_EN adds stall_cycles / words_out counters.
module y_tile_word_packer
  import ypack_pkg::*;
#(
  parameter int TILE_SIZE  = YP_TILE_SIZE,
  parameter int DATA_WIDTH = YP_DATA_WIDTH,
  parameter int DATA_W     = YP_DATA_W,
  parameter int D          = YP_D
) (
  input  logic clk,
  input  logic rst_n,
  y_tile_word_packer_if.master axis,
  input  logic flush,
  output logic vec_done,
  output logic busy
`ifdef YPACK_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] words_out
`endif
);
  if (DATA_W % (TILE_SIZE * DATA_WIDTH) != 0) begin : g_chk_tpw
    $error("DATA_W must be a multiple of TILE_SIZE*DATA_WIDTH");
  end
  if ((D * DATA_WIDTH) % DATA_W != 0) begin : g_chk_wpv
    $error("D*DATA_WIDTH must be a multiple of DATA_W");
  end
  if (WPV < 1) begin : g_chk_wpv_min
    $error("WPV must be at least 1");
  end
  if (TILE_SIZE != YP_TILE_SIZE || DATA_WIDTH != YP_DATA_WIDTH ||
      DATA_W != YP_DATA_W || D != YP_D) begin : g_chk_pkg
    $error("parameters must match ypack_pkg geometry");
  end

  logic [TCW-1:0] tile_cnt;
  logic [WCW-1:0] word_cnt;
  word_t pack;
  word_t merged;
  word_t ld_data;
  logic  flush_pend;
  logic  out_free;
  logic  has_data;
  logic  flush_go;
  logic  closing;
  logic  acc;
  logic  load;
  logic  ld_last;
  logic  wc_wrap;

  assign out_free = !axis.m_axis_TVALID || axis.m_axis_TREADY;
  assign has_data = (tile_cnt != '0) || (word_cnt != '0);
  assign flush_go = (flush || flush_pend) && has_data && out_free;
  assign closing  = tile_cnt == TCW'(TPW - 1);
  assign wc_wrap  = word_cnt == WCW'(WPV - 1);

  // No tile is taken while a flush is requested or waiting its turn.
  assign axis.y_axis_TREADY = (!closing || out_free) && !flush && !flush_pend;
  assign acc      = axis.y_axis_TVALID && axis.y_axis_TREADY;
  assign load     = (acc && closing) || flush_go;
  assign ld_data  = flush_go ? pack : merged;
  assign ld_last  = flush_go || wc_wrap;
  assign busy     = has_data || axis.m_axis_TVALID;

  always_comb begin
    merged = pack;
    for (int e = 0; e < TILE_SIZE; e++) begin
      merged[(int'(tile_cnt) * TILE_SIZE + e) * DATA_WIDTH +: DATA_WIDTH] =
        axis.y_axis_TDATA[e];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_cnt   <= '0;
      word_cnt   <= '0;
      pack       <= '0;
      flush_pend <= 1'b0;
    end else if (flush_go) begin
      tile_cnt   <= '0;
      word_cnt   <= '0;
      pack       <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (flush && has_data) flush_pend <= 1'b1;
      if (acc) begin
        if (closing) begin
          tile_cnt <= '0;
          word_cnt <= wc_wrap ? '0 : word_cnt + WCW'(1);
          pack     <= '0;
        end else begin
          tile_cnt <= tile_cnt + TCW'(1);
          pack     <= merged;
        end
      end
    end
  end

  y_word_out_reg u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (ld_data),
    .load_last (ld_last),
    .load_idx  (word_cnt),
    .ready     (axis.m_axis_TREADY),
    .valid     (axis.m_axis_TVALID),
    .data      (axis.m_axis_TDATA),
    .last      (axis.m_axis_TLAST),
    .idx       (axis.word_idx),
    .vec_done  (vec_done)
  );

`ifdef YPACK_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      words_out    <= '0;
    end else begin
      if (axis.m_axis_TVALID && !axis.m_axis_TREADY && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (axis.m_axis_TVALID && axis.m_axis_TREADY && words_out != '1)
        words_out <= words_out + 32'd1;
    end
  end
`endif
endmodule
